// File: rtl/disp_syncgen_if.sv
// rtl/disp_syncgen_if.sv - timing bundle from disp_syncgen to its consumers
//
// Carries the pixel/line counters, sync levels, display enable and strobes.
//   master : driven by disp_syncgen
//   slave  : character renderer / VGA pin driver side
//   HCNT, VCNT   pixel and line index (CW bits)
//   HSYNC, VSYNC sync levels, polarity set by the generator
//   DISP_EN      visible-area flag
//   LINE_END     pulse on the last pixel of every line
//   FRAME_START  pulse on pixel 0 of line 0
interface disp_syncgen_if #(
  parameter int CW = 10
);
  logic [CW-1:0] HCNT;
  logic [CW-1:0] VCNT;
  logic          HSYNC;
  logic          VSYNC;
  logic          DISP_EN;
  logic          LINE_END;
  logic          FRAME_START;

  modport master (
    output HCNT, VCNT, HSYNC, VSYNC, DISP_EN, LINE_END, FRAME_START
  );

  modport slave (
    input HCNT, VCNT, HSYNC, VSYNC, DISP_EN, LINE_END, FRAME_START
  );
endinterface

// File: rtl/disp_syncgen.sv
// rtl/disp_syncgen.sv - display timing generator (counters, syncs, enable, strobes)
//
// Ports:
//   PCK      pixel clock, rising edge
//   RST_N    asynchronous active-low reset
//   sync_if  master side of disp_syncgen_if: HCNT, VCNT, HSYNC, VSYNC,
//            DISP_EN, LINE_END, FRAME_START
//
// Every output is a flop loaded from values decoded off the *next* counter
// values, so each output always describes the HCNT/VCNT shown in the same
// cycle while nothing combinational sits between the counters and the pins.
module disp_syncgen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 10
) (
  input  logic PCK,
  input  logic RST_N,
  disp_syncgen_if.master sync_if
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FP     = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BP     = 2'd3
  } state_t;

  localparam int H_SYNC_AT = H_ACTIVE + H_FP;
  localparam int H_BP_AT   = H_SYNC_AT + H_SYNC;
  localparam int H_TOTAL   = H_BP_AT + H_BP;
  localparam int V_SYNC_AT = V_ACTIVE + V_FP;
  localparam int V_BP_AT   = V_SYNC_AT + V_SYNC;
  localparam int V_TOTAL   = V_BP_AT + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // Reset parks the counters on the last pixel of the last line; the state
  // registers must agree with that position, which is BP unless BP is empty.
  localparam state_t H_RST_ST = (H_BP > 0) ? ST_BP : ST_SYNC;
  localparam state_t V_RST_ST = (V_BP > 0) ? ST_BP : ST_SYNC;

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  state_t        hstate_q, hstate_d;
  state_t        vstate_q, vstate_d;
  logic          line_wrap;
  logic [31:0]   hn, vn;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic de_q, de_d;
  logic le_q, le_d;
  logic fs_q, fs_d;

  // State register: counters and both FSMs.
  always_ff @(posedge PCK or negedge RST_N) begin
    if (!RST_N) begin
      hcnt_q   <= H_LAST;
      vcnt_q   <= V_LAST;
      hstate_q <= H_RST_ST;
      vstate_q <= V_RST_ST;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      hstate_q <= hstate_d;
      vstate_q <= vstate_d;
    end
  end

  // Next-state logic: counters first, then FSM transitions keyed on the
  // next counter values. A zero-width porch makes its entry boundary
  // coincide with the following one, so the earlier branch jumps straight
  // past it.
  always_comb begin
    line_wrap = (hcnt_q == H_LAST);
    hcnt_d    = line_wrap ? '0 : hcnt_q + CW'(1);
    vcnt_d    = vcnt_q;
    if (line_wrap) begin
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
    end

    hn = 32'(hcnt_d);
    vn = 32'(vcnt_d);

    hstate_d = hstate_q;
    if (hn == 0) begin
      hstate_d = ST_ACTIVE;
    end else if (hn == H_ACTIVE) begin
      hstate_d = (H_FP > 0) ? ST_FP : ST_SYNC;
    end else if (hn == H_SYNC_AT) begin
      hstate_d = ST_SYNC;
    end else if (hn == H_BP_AT) begin
      hstate_d = ST_BP;
    end

    vstate_d = vstate_q;
    if (line_wrap) begin
      if (vn == 0) begin
        vstate_d = ST_ACTIVE;
      end else if (vn == V_ACTIVE) begin
        vstate_d = (V_FP > 0) ? ST_FP : ST_SYNC;
      end else if (vn == V_SYNC_AT) begin
        vstate_d = ST_SYNC;
      end else if (vn == V_BP_AT) begin
        vstate_d = ST_BP;
      end
    end
  end

  // Output decode from the next state / next counters.
  always_comb begin
    hsync_d = (hstate_d == ST_SYNC) ? HS_ON : ~HS_ON;
    vsync_d = (vstate_d == ST_SYNC) ? VS_ON : ~VS_ON;
    de_d    = (hstate_d == ST_ACTIVE) && (vstate_d == ST_ACTIVE);
    le_d    = (hcnt_d == H_LAST);
    fs_d    = (hcnt_d == '0) && (vcnt_d == '0);
  end

  // Output flops: reset drops sync to its idle level at once.
  always_ff @(posedge PCK or negedge RST_N) begin
    if (!RST_N) begin
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      de_q    <= 1'b0;
      le_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      le_q    <= le_d;
      fs_q    <= fs_d;
    end
  end

  assign sync_if.HCNT        = hcnt_q;
  assign sync_if.VCNT        = vcnt_q;
  assign sync_if.HSYNC       = hsync_q;
  assign sync_if.VSYNC       = vsync_q;
  assign sync_if.DISP_EN     = de_q;
  assign sync_if.LINE_END    = le_q;
  assign sync_if.FRAME_START = fs_q;

endmodule
